// File: rtl/seg7_display_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_display_ctrl
//
// Display stage for the ALU result bus. A 16-bit unsigned value is converted
// to five BCD digits by a sequential shift-add-3 (double-dabble) engine. The
// lower four digits drive a time-multiplexed 4-digit seven-segment display.
// The ten-thousands digit (0..6) is shown on four discrete LEDs.
//
// Parameters:
//   SCAN_DIV      clock cycles each digit stays enabled (must be >= 2)
//
// Ports:
//   Clk           in   1   single clock, everything is posedge
//   RESET         in   1   synchronous, active-high reset
//   Binary        in  16   value to display (ALU result)
//   SevenSegment  out  7   active-low segments {g,f,e,d,c,b,a}, registered
//   Enable        out  4   active-low digit anodes, one-hot-low, bit0 = ones
//   LEDs          out  4   BCD ten-thousands digit of last finished conversion
//
// Optional feature macro:
//   SEG7_LEADING_ZERO_BLANK_EN  when defined, leading zero digits 3..1 are
//                               blanked (LEDs counts as the highest digit).
// ---------------------------------------------------------------------------
module seg7_display_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic [15:0] Binary,
  output logic [6:0]  SevenSegment,
  output logic [3:0]  Enable,
  output logic [3:0]  LEDs
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Conversion engine state
  state_t      state_q,   state_d;
  logic [15:0] lastVal_q, lastVal_d;
  logic [35:0] shreg_q,   shreg_d;
  logic [4:0]  bitCnt_q,  bitCnt_d;

  // Display registers, only written when a conversion completes
  logic [3:0]  dig0_q, dig0_d;
  logic [3:0]  dig1_q, dig1_d;
  logic [3:0]  dig2_q, dig2_d;
  logic [3:0]  dig3_q, dig3_d;
  logic [3:0]  leds_q, leds_d;

  // Scan timing
  logic [CNT_W-1:0] scanCnt_q, scanCnt_d;
  logic [1:0]       idx_q,     idx_d;

  // Registered output stage
  logic [3:0] enable_q, enable_d;
  logic [6:0] seg_q,    seg_d;

  // Shift register after the add-3 correction of every BCD nibble
  logic [35:0] adjusted;

  // Active-low seven-segment decode; anything outside 0..9 is dark.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Double-dabble correction: any BCD nibble of 5 or more gets 3 added so
  // that the following left shift carries correctly into the next decade.
  // The binary part in the low 16 bits is passed through untouched.
  always_comb begin
    adjusted = shreg_q;
    for (int i = 0; i < 5; i++) begin
      if (shreg_q[16 + 4*i +: 4] >= 4'd5) begin
        adjusted[16 + 4*i +: 4] = shreg_q[16 + 4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM next-state logic. IDLE watches for a new input value,
  // SHIFT runs exactly 16 correct-and-shift steps, DONE publishes the five
  // digits at once so a half-converted value is never visible. Input changes
  // during SHIFT/DONE are simply picked up by the next IDLE cycle.
  always_comb begin
    state_d   = state_q;
    lastVal_d = lastVal_q;
    shreg_d   = shreg_q;
    bitCnt_d  = bitCnt_q;
    dig0_d    = dig0_q;
    dig1_d    = dig1_q;
    dig2_d    = dig2_q;
    dig3_d    = dig3_q;
    leds_d    = leds_q;

    case (state_q)
      IDLE: begin
        if (Binary != lastVal_q) begin
          lastVal_d = Binary;
          shreg_d   = {20'd0, Binary};
          bitCnt_d  = 5'd0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        shreg_d  = adjusted << 1;
        bitCnt_d = bitCnt_q + 5'd1;
        if (bitCnt_q == 5'd15) begin
          state_d = DONE;
        end
      end

      DONE: begin
        dig0_d  = shreg_q[19:16];
        dig1_d  = shreg_q[23:20];
        dig2_d  = shreg_q[27:24];
        dig3_d  = shreg_q[31:28];
        leds_d  = shreg_q[35:32];
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Conversion state and display registers. Reset abandons any conversion
  // in flight and clears the remembered value, so a nonzero input present
  // at release is converted again from scratch.
  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q   <= IDLE;
      lastVal_q <= '0;
      shreg_q   <= '0;
      bitCnt_q  <= '0;
      dig0_q    <= '0;
      dig1_q    <= '0;
      dig2_q    <= '0;
      dig3_q    <= '0;
      leds_q    <= '0;
    end else begin
      state_q   <= state_d;
      lastVal_q <= lastVal_d;
      shreg_q   <= shreg_d;
      bitCnt_q  <= bitCnt_d;
      dig0_q    <= dig0_d;
      dig1_q    <= dig1_d;
      dig2_q    <= dig2_d;
      dig3_q    <= dig3_d;
      leds_q    <= leds_d;
    end
  end

  // Scan divider: each digit is enabled for SCAN_DIV cycles, then the digit
  // index advances 0 -> 1 -> 2 -> 3 -> 0 (2-bit wrap does the last step).
  always_comb begin
    scanCnt_d = scanCnt_q + 1'b1;
    idx_d     = idx_q;
    if (scanCnt_q == SCAN_LAST) begin
      scanCnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      scanCnt_q <= '0;
      idx_q     <= '0;
    end else begin
      scanCnt_q <= scanCnt_d;
      idx_q     <= idx_d;
    end
  end

  // Output stage: select the digit addressed by the current scan index and
  // decode it. Enable and SevenSegment are computed from the same idx_q so
  // they always move together, one cycle behind idx and the digit registers.
  always_comb begin
    logic [3:0] selDig;
    logic       blank;

    selDig = dig0_q;
    blank  = 1'b0;

    case (idx_q)
      2'd0:    selDig = dig0_q;
      2'd1:    selDig = dig1_q;
      2'd2:    selDig = dig2_q;
      default: selDig = dig3_q;
    endcase

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every more significant digit (LEDs
    // included) are zero. The ones digit always shows so 0 reads as "0".
    begin
      logic blank3, blank2, blank1;
      blank3 = (leds_q == 4'd0) && (dig3_q == 4'd0);
      blank2 = blank3 && (dig2_q == 4'd0);
      blank1 = blank2 && (dig1_q == 4'd0);
      case (idx_q)
        2'd1:    blank = blank1;
        2'd2:    blank = blank2;
        2'd3:    blank = blank3;
        default: blank = 1'b0;
      endcase
    end
`else
    blank = 1'b0;
`endif

    enable_d = ~(4'b0001 << idx_q);
    seg_d    = blank ? 7'b1111111 : decode(selDig);
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      enable_q <= 4'b1110;
      seg_q    <= 7'b1000000;
    end else begin
      enable_q <= enable_d;
      seg_q    <= seg_d;
    end
  end

  assign SevenSegment = seg_q;
  assign Enable       = enable_q;
  assign LEDs         = leds_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_display_ctrl
//
// Directed self-checking bench for seg7_display_ctrl with SCAN_DIV = 4.
// Expected segment patterns and digits are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_seg7_display_ctrl;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] binary;
  logic [6:0]  sevenSegment;
  logic [3:0]  enable;
  logic [3:0]  leds;

  int testCount = 0;
  int failCount = 0;

  seg7_display_ctrl #(.SCAN_DIV(4)) dut (
    .Clk          (clock),
    .RESET        (reset),
    .Binary       (binary),
    .SevenSegment (sevenSegment),
    .Enable       (enable),
    .LEDs         (leds)
  );

  // 10 ns clock
  always #5 clock = ~clock;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  // Drive a new input value right after a falling edge
  task automatic applyStimulus(input logic [15:0] value);
    @(negedge clock);
    binary = value;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Wait (bounded) until digit k is enabled, then check its segments.
  // Must be called at a falling edge.
  task automatic checkDigit(input string tag, input int k, input logic [6:0] expSeg);
    logic [3:0] want;
    want = ~(4'b0001 << k);
    for (int i = 0; i < 20; i++) begin
      if (enable == want) break;
      @(negedge clock);
    end
    checkOutput({tag, "_enable"}, 32'(enable), 32'(want));
    checkOutput({tag, "_seg"}, 32'(sevenSegment), 32'(expSeg));
  endtask

  initial begin
    reset  = 1'b1;
    binary = 16'd0;

    // Reset held for two edges
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_enable", 32'(enable), 32'(4'b1110));
    checkOutput("reset_seg", 32'(sevenSegment), 32'(SEG_0));
    checkOutput("reset_leds", 32'(leds), 32'(4'd0));
    reset = 1'b0;

    // Binary equals last value (0): nothing converts, display stays 0
    waitCycles(30);
    checkOutput("idle_leds", 32'(leds), 32'(4'd0));
    checkDigit("idle_d2", 2, SEG_0);

    // Basic conversion 1234
    applyStimulus(16'd1234);
    waitCycles(30);
    checkDigit("b1234_d0", 0, SEG_4);
    checkDigit("b1234_d3", 3, SEG_1);
    checkDigit("b1234_d2", 2, SEG_2);
    checkDigit("b1234_d1", 1, SEG_3);

    // Mid-conversion change: 9999 detected at E0, 42 applied after E4
    waitCycles(5);
    applyStimulus(16'd9999);
    repeat (5) @(posedge clock);
    @(negedge clock);
    binary = 16'd42;
    repeat (14) @(posedge clock);
    @(negedge clock);
    checkDigit("mid9999_d3", 3, SEG_9);
    waitCycles(40);
    checkDigit("b42_d0", 0, SEG_2);
    checkDigit("b42_d1", 1, SEG_4);
    checkDigit("b42_d2", 2, SEG_0);
    checkDigit("b42_d3", 3, SEG_0);
    checkOutput("b42_leds", 32'(leds), 32'(4'd0));

    // Full scale 65535, with LEDs latency: unchanged after E16, 6 after E17
    waitCycles(5);
    applyStimulus(16'd65535);
    repeat (17) @(posedge clock);
    @(negedge clock);
    checkOutput("full_leds_before_done", 32'(leds), 32'(4'd0));
    @(posedge clock);
    @(negedge clock);
    checkOutput("full_leds", 32'(leds), 32'(4'd6));
    waitCycles(5);
    checkDigit("full_d0", 0, SEG_5);
    checkDigit("full_d1", 1, SEG_3);
    checkDigit("full_d2", 2, SEG_5);
    checkDigit("full_d3", 3, SEG_5);

    // Reset during SHIFT while converting 500
    waitCycles(5);
    applyStimulus(16'd500);
    repeat (6) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("midrst_enable", 32'(enable), 32'(4'b1110));
    checkOutput("midrst_seg", 32'(sevenSegment), 32'(SEG_0));
    checkOutput("midrst_leds", 32'(leds), 32'(4'd0));
    reset = 1'b0;
    waitCycles(40);
    checkDigit("b500_d0", 0, SEG_0);
    checkDigit("b500_d1", 1, SEG_0);
    checkDigit("b500_d2", 2, SEG_5);
    checkDigit("b500_d3", 3, SEG_0);

    // Leading-zero behaviour with 7
    applyStimulus(16'd7);
    waitCycles(30);
    checkDigit("b7_d0", 0, SEG_7);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    checkDigit("b7_d1", 1, SEG_BLANK);
    checkDigit("b7_d2", 2, SEG_BLANK);
    checkDigit("b7_d3", 3, SEG_BLANK);
`else
    checkDigit("b7_d1", 1, SEG_0);
    checkDigit("b7_d2", 2, SEG_0);
    checkDigit("b7_d3", 3, SEG_0);
`endif

    // 10000: LEDs nonzero, so no digit is blanked in either build
    applyStimulus(16'd10000);
    waitCycles(30);
    checkOutput("b10000_leds", 32'(leds), 32'(4'd1));
    checkDigit("b10000_d0", 0, SEG_0);
    checkDigit("b10000_d1", 1, SEG_0);
    checkDigit("b10000_d2", 2, SEG_0);
    checkDigit("b10000_d3", 3, SEG_0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/seg7_display_ctrl.md
# seg7_display_ctrl

Downstream display stage for the ALU result bus. Converts the 16-bit unsigned result into BCD with a sequential shift-add-3 (double-dabble) engine and drives a 4-digit multiplexed seven-segment display. The ten-thousands digit is presented on the 4 discrete LEDs. It is the consumer of the ALU output `C` in the register-file demo top level.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays enabled; must be ≥ 2.
- `Clk`  in  1: single clock; all logic is posedge.
- `RESET`  in  1: synchronous, active-high reset.
- `Binary`  in  16: unsigned value to display, sampled directly from the ALU result.
- `SevenSegment`  out  7: active-low segments, bit order {g,f,e,d,c,b,a}; registered.
- `Enable`  out  4: active-low digit anodes, one-hot-low; bit 0 is the ones digit; registered.
- `LEDs`  out  4: BCD ten-thousands digit (0–6) of the last completed conversion; registered.

## Operation
- Conversion FSM states:
  - IDLE: if `Binary != last_val`, load `last_val <= Binary` and `shreg <= {20'd0, Binary}`, clear `bit_cnt`, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, add 3 to every BCD nibble of `shreg[35:16]` that is ≥ 5, then shift the whole register left by 1. `bit_cnt` increments. After 16 shifts, go to DONE.
  - DONE: copy the five BCD nibbles into the display registers `dig0..dig3` and `LEDs`, then go to IDLE.
- Changes on `Binary` during SHIFT or DONE are ignored. They are detected on the first IDLE cycle afterwards, so the last value always converges.
- Display registers change only in DONE. No partially converted value is ever shown.
- Scan: `scan_cnt` counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and `idx` advances 0→1→2→3→0.
- Output stage (every cycle): `Enable <= ~(4'b0001 << idx)`; `SevenSegment <= decode(dig[idx])`.
- Decode table, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Any other nibble decodes to 1111111.
- Arithmetic: 36-bit shift register (20 BCD bits + 16 binary bits). The maximum input 65535 yields LEDs=6 and dig3..dig0=5,5,3,5.

## Timing
- Reset values:
  - state IDLE, `last_val`=0, `dig0..dig3`=0, `LEDs`=0, `scan_cnt`=0, `idx`=0.
  - `Enable`=1110, `SevenSegment`=1000000.
  - Reset has priority over all other activity, including mid-conversion; the conversion is abandoned.
- Latency: take E0 as the edge where IDLE sees the new value. Shifts occur on E1..E16. Display registers update on E17. `SevenSegment` reflects the new digit after E18, i.e. 18 edges after detection.
- `SevenSegment` and `Enable` lag `idx` and the `dig` registers by exactly one cycle, and always change on the same edge.
- If `Binary` returns to `last_val` before IDLE samples it, no conversion is started.
- Scan wrap and a DONE update may fall on the same edge. Both take effect; the output stage uses the new `idx` and new digits on the following edge.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN`:
  - Defined: digit k (k=3,2,1) drives 1111111 when `dig[k]` and every higher digit are zero, with `LEDs` counted as the highest digit. Digit 0 is never blanked. `Enable` is unaffected.
  - Undefined: all four digits always display, including leading zeros.

## Test plan
- Reset: hold RESET for 2 edges with `Binary`=0 → `Enable`=1110, `SevenSegment`=1000000, `LEDs`=0; no conversion starts because 0 equals `last_val`.
- Basic conversion: `SCAN_DIV`=4, `Binary`=1234 → display registers are 1,2,3,4 on the 18th edge. The ones digit then shows 0011001. Stepping through `idx`, `Enable` goes 1101 → 0110000 (digit 3), 1011 → 0100100 (digit 2), 0111 → 1111001 (digit 1).
- Full-scale input: `Binary`=65535 → `LEDs`=6; digits 5,3,5,5 (ones upward) decode to 0010010, 0110000, 0010010, 0010010.
- Mid-conversion change: `Binary`=9999, then 42 at 5 edges after detection → 9999 is displayed first. 42 is detected on the next IDLE cycle and 0042 is displayed 18 edges later; 9999 is never corrupted.
- Reset mid-conversion: assert RESET during SHIFT while `Binary`=500 → all outputs return to reset values. After release, 500 is reconverted and displayed correctly.
- Blanking: `Binary`=7.
  - With `SEG7_LEADING_ZERO_BLANK_EN` defined: digits 3..1 output 1111111 and digit 0 outputs 1111000.
  - Without it: digits 3..1 output 1000000.
  - `Binary`=10000 with the macro defined: `LEDs`=1 and all four digits show 1000000.
